// File: rtl/addsub_vector_checker.sv
// Sweeps every {k, a, b} vector into a WIDTH-bit add/sub unit, checks the returned {cout, res}
// against an internal expectation, counts mismatches and captures the first failing vector.
module addsub_vector_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               k_out,
    output logic               cin_out,
    input  logic [WIDTH-1:0]   res_in,
    input  logic               cout_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_k,
    output logic               fail_valid
);

    localparam int IW = 2*WIDTH + 1;
    localparam int CW = 2*WIDTH + 2;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [SW-1:0]   settle_cnt;
    logic            cur_k;
    logic [WIDTH-1:0] cur_a, cur_b;
    logic [WIDTH:0]  expected;
    logic            start_sweep, last_hold, last_vec, cmp_err;
    logic [CW-1:0]   err_nxt;

    assign cur_k = idx[IW-1];
    assign cur_a = idx[IW-2:WIDTH];
    assign cur_b = idx[WIDTH-1:0];

    // Operands come straight off the index register, so they are registered outputs.
    assign a_out   = cur_a;
    assign b_out   = cur_b;
    assign k_out   = cur_k;
    assign cin_out = cur_k;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    // Subtract is a + ~b + 1 at WIDTH+1 bits; carry-out high means no borrow.
    assign expected = {1'b0, cur_a} + {1'b0, (cur_k ? ~cur_b : cur_b)} + {{WIDTH{1'b0}}, cur_k};

    assign start_sweep = (state != RUN) && start;
    assign last_hold   = (state == RUN) && (settle_cnt == SETTLE_LAST);
    assign last_vec    = (idx == {IW{1'b1}});
    assign cmp_err     = last_hold && ({cout_in, res_in} != expected);
    assign err_nxt     = (cmp_err && (err_count != {CW{1'b1}})) ? err_count + CW'(1) : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (last_hold && last_vec) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_k     <= 1'b0;
            fail_valid <= 1'b0;
        end else if (start_sweep) begin
            idx        <= '0;
            settle_cnt <= '0;
            err_count  <= '0;
            pass       <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_k     <= 1'b0;
            fail_valid <= 1'b0;
        end else if (last_hold) begin
            err_count <= err_nxt;
            if (cmp_err && !fail_valid) begin
                fail_a     <= cur_a;
                fail_b     <= cur_b;
                fail_k     <= cur_k;
                fail_valid <= 1'b1;
            end
            // Final compare is folded in before pass is decided.
            if (last_vec) begin
                pass <= (err_nxt == '0);
            end else begin
                idx        <= idx + IW'(1);
                settle_cnt <= '0;
            end
        end else if (state == RUN) begin
            settle_cnt <= settle_cnt + SW'(1);
        end
    end

endmodule
